// File: rtl/mem_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register
// offsets, STATUS bit positions and the transmit FSM state encoding.
package mem_uart_pkg;

   // Register select taken from mem_addr[3:2]
   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_DIV    = 2'd2;
   localparam logic [1:0] REG_CTRL   = 2'd3;

   // STATUS bit positions
   localparam int ST_BUSY      = 0;
   localparam int ST_FULL      = 1;
   localparam int ST_EMPTY     = 2;
   localparam int ST_LEVEL_LSB = 4;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_t;

   // A divider of zero would stall the bit timer, so it behaves as one.
   function automatic logic [15:0] div_eff(input logic [15:0] d);
      return (d == 16'd0) ? 16'd1 : d;
   endfunction

endpackage

// File: rtl/mem_uart_fifo.sv
// Byte-wide synchronous FIFO feeding the transmitter. Pushes when full
// and pops when empty are dropped; pointers wrap modulo DEPTH.
module mem_uart_fifo #(
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          push,
   input  logic [7:0]    wdata,
   input  logic          pop,
   output logic [7:0]    rdata,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   level
);

   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push_ok;
   logic          pop_ok;

   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign full    = (level == FULL_LVL);
   assign empty   = (level == '0);
   assign rdata   = mem[rd_ptr];

   // Storage array; contents need no reset since level gates every read.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= wdata;
   end

   // Pointers and occupancy; simultaneous push and pop leave level unchanged.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   level <= level + (AW+1)'(1);
            2'b01:   level <= level - (AW+1)'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/mem_uart_tx.sv
// Memory-mapped UART transmitter: a four-register slave (DATA, STATUS,
// DIV, CTRL) in front of a byte FIFO and an 8N1 serialiser.
// Optional feature macro: MEM_UART_TX_IRQ_EN adds CTRL[0] irq_en and the
// registered TX-empty interrupt output irq; without it CTRL reads 0.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// TX_IDLE  | line high, waiting for a byte in the FIFO
// TX_START | start bit (line low) for one bit period
// TX_DATA  | eight data bits, LSB first, one bit period each
// TX_STOP  | stop bit (line high) for one bit period
module mem_uart_tx
   import mem_uart_pkg::*;
#(
   parameter int          FIFO_DEPTH  = 8,
   parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        mem_valid,
   output logic        mem_ready,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic [31:0] mem_rdata,
   output logic        uart_tx
`ifdef MEM_UART_TX_IRQ_EN
   ,
   output logic        irq
`endif
);

   localparam int AW = $clog2(FIFO_DEPTH);

   tx_state_t   state;
   tx_state_t   state_nxt;
   logic [15:0] div_reg;
   logic [15:0] div_lat;
   logic [15:0] bit_cnt;
   logic [2:0]  bit_idx;
   logic [7:0]  shift;
   logic        bit_tick;
   logic        busy;
   logic        pop;
   logic        push;
   logic        accept;
   logic        is_wr;
   logic        is_data_wr;
   logic [31:0] rd_val;
   logic [7:0]  fifo_rdata;
   logic        fifo_full;
   logic        fifo_empty;
   logic [AW:0] fifo_level;
   logic [3:0]  lvl4;
   logic        unused_bits;
`ifdef MEM_UART_TX_IRQ_EN
   logic        irq_en;
`endif

   // Address and strobe bits the decoder ignores.
   assign unused_bits = ^{mem_addr[31:4], mem_addr[1:0], mem_wdata[31:16], mem_wstrb[3:2]};

   assign is_wr      = |mem_wstrb;
   assign is_data_wr = is_wr && (mem_addr[3:2] == REG_DATA);
   // A DATA write against a full FIFO holds off until a pop frees a slot.
   assign accept     = mem_valid & ~mem_ready & ~(is_data_wr & fifo_full);
   assign push       = accept & is_data_wr & mem_wstrb[0];
   assign lvl4       = 4'(fifo_level);
   assign bit_tick   = (bit_cnt == 16'd0);

   mem_uart_fifo #(
      .DEPTH (FIFO_DEPTH),
      .AW    (AW)
   ) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (push),
      .wdata (mem_wdata[7:0]),
      .pop   (pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   // Read multiplexer; reads never change state.
   always_comb begin
      rd_val = '0;
      case (mem_addr[3:2])
         REG_STATUS: begin
            rd_val[ST_LEVEL_LSB +: 4] = lvl4;
            rd_val[ST_EMPTY]          = fifo_empty;
            rd_val[ST_FULL]           = fifo_full;
            rd_val[ST_BUSY]           = busy;
         end
         REG_DIV:  rd_val[15:0] = div_reg;
`ifdef MEM_UART_TX_IRQ_EN
         REG_CTRL: rd_val[0] = irq_en;
`endif
         default:  rd_val = '0;
      endcase
   end

   // Bus handshake: one-cycle ready pulse, read data only alongside it.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mem_ready <= 1'b0;
         mem_rdata <= '0;
      end else begin
         mem_ready <= accept;
         mem_rdata <= (accept && !is_wr) ? rd_val : 32'd0;
      end
   end

   // Divider register with per-byte strobes.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         div_reg <= DEFAULT_DIV;
      end else if (accept && is_wr && mem_addr[3:2] == REG_DIV) begin
         if (mem_wstrb[0]) div_reg[7:0]  <= mem_wdata[7:0];
         if (mem_wstrb[1]) div_reg[15:8] <= mem_wdata[15:8];
      end
   end

`ifdef MEM_UART_TX_IRQ_EN
   // Interrupt enable and registered TX-empty interrupt.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         irq_en <= 1'b0;
         irq    <= 1'b0;
      end else begin
         if (accept && mem_wstrb[0] && mem_addr[3:2] == REG_CTRL) irq_en <= mem_wdata[0];
         irq <= irq_en & fifo_empty & ~busy;
      end
   end
`endif

   // FSM state register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= TX_IDLE;
      else       state <= state_nxt;
   end

   // FSM next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         TX_IDLE:  if (!fifo_empty) state_nxt = TX_START;
         TX_START: if (bit_tick) state_nxt = TX_DATA;
         TX_DATA:  if (bit_tick && bit_idx == 3'd7) state_nxt = TX_STOP;
         TX_STOP:  if (bit_tick) state_nxt = TX_IDLE;
         default:  state_nxt = TX_IDLE;
      endcase
   end

   // FSM outputs: line level, FIFO pop on frame start, busy flag.
   always_comb begin
      uart_tx = 1'b1;
      pop     = 1'b0;
      busy    = 1'b1;
      case (state)
         TX_IDLE: begin
            busy = 1'b0;
            pop  = ~fifo_empty;
         end
         TX_START: uart_tx = 1'b0;
         TX_DATA:  uart_tx = shift[0];
         default:  uart_tx = 1'b1;
      endcase
   end

   // Bit timer (down-counter to zero) and shift register; the divider is
   // captured at frame start so mid-frame DIV writes wait for the next frame.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         div_lat <= 16'd1;
         bit_cnt <= '0;
         bit_idx <= '0;
         shift   <= '0;
      end else if (state == TX_IDLE) begin
         if (!fifo_empty) begin
            div_lat <= div_eff(div_reg);
            bit_cnt <= div_eff(div_reg) - 16'd1;
            bit_idx <= '0;
            shift   <= fifo_rdata;
         end
      end else if (bit_tick) begin
         bit_cnt <= div_lat - 16'd1;
         if (state == TX_DATA) begin
            shift   <= {1'b0, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
         end
      end else begin
         bit_cnt <= bit_cnt - 16'd1;
      end
   end

endmodule

// File: doc/mem_uart_tx.md
MEM_UART_TX -- requirements
Module: mem_uart_tx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, TX FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter DEFAULT_DIV, default 16'd434, reset value of DIV (clock cycles per bit).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port mem_valid  input  1  bus request from initiator, held until mem_ready.
REQ-006 SHALL have port mem_ready  output  1  one-cycle completion pulse.
REQ-007 SHALL have port mem_addr  input  32  byte address; only [3:2] decoded.
REQ-008 SHALL have port mem_wdata  input  32  write data.
REQ-009 SHALL have port mem_wstrb  input  4  byte strobes; 0 = read, nonzero = write.
REQ-010 SHALL have port mem_rdata  output  32  read data, valid while mem_ready=1.
REQ-011 SHALL have port uart_tx  output  1  serial line, idle high.
REQ-012 SHALL have port irq  output  1  TX-empty interrupt (only with MEM_UART_TX_IRQ_EN).

Function
REQ-013 SHALL decode registers by mem_addr[3:2]: 0 DATA, 1 STATUS, 2 DIV, 3 CTRL.
REQ-014 SHALL perform an access at the edge sampling mem_valid=1, mem_ready=0, and accept condition true; mem_ready=1 in the following cycle only, then 0.
REQ-015 SHALL treat accept condition as true except a DATA write while FIFO full (registered count), which stalls with mem_ready=0 until space exists.
REQ-016 SHALL, on DATA write with mem_wstrb[0]=1, push mem_wdata[7:0]; wstrb[0]=0 completes without push.
REQ-017 SHALL return STATUS = {24'b0, level[3:0], 1'b0, empty, full, busy}; busy=1 when FSM not IDLE.
REQ-018 SHALL provide DIV as 16-bit RW register in [15:0], per-byte strobed; value 0 treated as 1.
REQ-019 SHALL read DATA as 0; unused bits read 0; reads have no side effects.
REQ-020 SHALL implement FSM IDLE->START->DATA(8 bits, LSB first)->STOP->IDLE, each state bit period DIV cycles.
REQ-021 SHALL pop FIFO on IDLE->START transition, taken the cycle after IDLE observes non-empty.
REQ-022 SHALL latch DIV at frame start; DIV writes mid-frame affect next frame only.
REQ-023 SHALL drive uart_tx 0 in START, data bit in DATA, 1 in STOP and IDLE.
REQ-024 SHALL, on simultaneous push and pop, keep level unchanged; push when full never overwrites.
REQ-025 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH.

Reset
REQ-026 SHALL, on rstn=0, immediately force: mem_ready=0, mem_rdata=0, uart_tx=1, irq=0, FSM IDLE, FIFO empty, DIV=DEFAULT_DIV, CTRL=0.
REQ-027 SHALL abort any frame in progress on reset; line returns high with no partial-frame recovery.

Configuration
REQ-028 SHALL, with MEM_UART_TX_IRQ_EN defined, implement CTRL[0] irq_en (RW) and irq = irq_en & empty & !busy, registered.
REQ-029 SHALL, without MEM_UART_TX_IRQ_EN, omit irq port and CTRL storage; CTRL reads 0, writes ignored.

Structure
REQ-030 SHALL place register offsets, STATUS bit indices and FSM state enum in shared package mem_uart_pkg.
REQ-031 SHALL instantiate sub-module mem_uart_fifo (synchronous FIFO, push/pop/full/empty/level).

Verification
REQ-032 SHALL cover: reset, read STATUS -> rdata=32'h00000004, uart_tx=1, DIV reads 434.
REQ-033 SHALL cover: DIV=4, write DATA 8'hA5 -> uart_tx 0,1,0,1,0,0,1,0,1,1 each held 4 cycles (40 total).
REQ-034 SHALL cover: 9 DATA writes with DIV=4, FIFO_DEPTH=8 while busy -> 9th write mem_ready delayed until first pop; all 9 bytes sent in order.
REQ-035 SHALL cover: write DIV=8 mid-frame at DIV=4 -> current frame 4 cycles/bit, next frame 8 cycles/bit.
REQ-036 SHALL cover: rstn low during DATA bit 3 -> uart_tx=1 same cycle, STATUS empty=1 after release.
REQ-037 SHALL cover (IRQ_EN): CTRL=1, send one byte -> irq=0 during frame, irq=1 after stop bit completes.
